// File: rtl/cache_mem_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mem_arbiter_pkg : bus widths and FSM/owner encodings for the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

    localparam int CACHE_MEM_ADDR_W = 32;
    localparam int CACHE_MEM_DATA_W = 32;
    localparam int CACHE_MEM_BE_W   = CACHE_MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 : two-request picker; remembers the last granted master
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick2
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic req_d,
    input  logic load,
    output logic pick
);

    logic r_last;

    // Ties go to the master not granted last time, or always to D without RR.
    always_comb begin
        pick = OWN_D;
        if (req_i && !req_d)
            pick = OWN_I;
        else if (req_i && req_d && RR_EN && (r_last == OWN_D))
            pick = OWN_I;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last <= OWN_D;
        else if (load)
            r_last <= pick;
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cache_mem_arbiter : icache/dcache to main-memory arbiter, one txn in flight
// Rev 1.0
// ---------------------------------------------------------------------------
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [CACHE_MEM_ADDR_W-1:0] i_i_addr,
    input  logic [CACHE_MEM_BE_W-1:0]   i_i_byte_en,
    input  logic [CACHE_MEM_DATA_W-1:0] i_i_writedata,
    input  logic                        i_i_read,
    input  logic                        i_i_write,
    output logic [CACHE_MEM_DATA_W-1:0] o_i_readdata,
    output logic                        o_i_readdata_valid,
    output logic                        o_i_waitrequest,
    input  logic [CACHE_MEM_ADDR_W-1:0] i_d_addr,
    input  logic [CACHE_MEM_BE_W-1:0]   i_d_byte_en,
    input  logic [CACHE_MEM_DATA_W-1:0] i_d_writedata,
    input  logic                        i_d_read,
    input  logic                        i_d_write,
    output logic [CACHE_MEM_DATA_W-1:0] o_d_readdata,
    output logic                        o_d_readdata_valid,
    output logic                        o_d_waitrequest,
    output logic [CACHE_MEM_ADDR_W-1:0] o_m_addr,
    output logic [CACHE_MEM_BE_W-1:0]   o_m_byte_en,
    output logic [CACHE_MEM_DATA_W-1:0] o_m_writedata,
    output logic                        o_m_read,
    output logic                        o_m_write,
    input  logic [CACHE_MEM_DATA_W-1:0] i_m_readdata,
    input  logic                        i_m_readdata_valid,
    input  logic                        i_m_waitrequest,
    output logic                        o_err
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    logic       r_err;

    logic w_any_i;
    logic w_any_d;
    logic w_pick;
    logic w_load;
    logic w_issue;
    logic w_busy;
    logic w_own_d;
    logic w_own_rd;
    logic w_own_wr;
    logic w_accept;

    assign w_any_i  = i_i_read | i_i_write;
    assign w_any_d  = i_d_read | i_d_write;
    assign w_issue  = (r_state == ST_ISSUE);
    assign w_busy   = w_issue | (r_state == ST_RDWAIT);
    assign w_own_d  = (r_owner == OWN_D);
    assign w_own_rd = w_own_d ? i_d_read  : i_i_read;
    assign w_own_wr = w_own_d ? i_d_write : i_i_write;
    assign w_accept = w_issue & (w_own_rd | w_own_wr) & ~i_m_waitrequest;
    assign w_load   = (r_state == ST_IDLE) & (w_any_i | w_any_d);

    rr_pick2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (w_any_i),
        .req_d (w_any_d),
        .load  (w_load),
        .pick  (w_pick)
    );

    assign o_m_addr      = w_own_d ? i_d_addr      : i_i_addr;
    assign o_m_byte_en   = w_own_d ? i_d_byte_en   : i_i_byte_en;
    assign o_m_writedata = w_own_d ? i_d_writedata : i_i_writedata;
    assign o_m_read      = w_issue & w_own_rd;
    assign o_m_write     = w_issue & w_own_wr;

    // Only the owner in ISSUE ever sees memory's stall; everyone else is held.
    assign o_i_waitrequest = ~(w_issue & ~w_own_d) | i_m_waitrequest;
    assign o_d_waitrequest = ~(w_issue &  w_own_d) | i_m_waitrequest;

    assign o_i_readdata       = w_own_d ? '0 : i_m_readdata;
    assign o_d_readdata       = w_own_d ? i_m_readdata : '0;
    assign o_i_readdata_valid = ~w_own_d & w_busy & i_m_readdata_valid;
    assign o_d_readdata_valid =  w_own_d & w_busy & i_m_readdata_valid;

    assign o_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_I;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_m_readdata_valid)
                        r_err <= 1'b1;
                    if (w_any_i | w_any_d) begin
                        r_owner <= arb_owner_t'(w_pick);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_m_readdata_valid && !(w_accept && w_own_rd))
                        r_err <= 1'b1;
                    if (!(w_own_rd | w_own_wr))
                        r_state <= ST_IDLE;
                    else if (w_accept)
                        r_state <= (w_own_rd && !i_m_readdata_valid) ? ST_RDWAIT : ST_IDLE;
                end
                ST_RDWAIT: begin
                    if (i_m_readdata_valid)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cache_mem_arbiter : vector table, corner sequences and random vs model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int AW = CACHE_MEM_ADDR_W;
    localparam int DW = CACHE_MEM_DATA_W;
    localparam int BW = CACHE_MEM_BE_W;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] i_addr, d_addr;
    logic [BW-1:0] i_be, d_be;
    logic [DW-1:0] i_wd, d_wd, m_rd;
    logic          i_rd, i_wr, d_rd, d_wr, m_wait, m_val;

    logic [DW-1:0] i_rdata, d_rdata, m_wd;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_be;
    logic          i_val, d_val, i_wait, d_wait, m_read, m_write, err;

    logic [DW-1:0] f_i_rdata, f_d_rdata, f_m_wd;
    logic [AW-1:0] f_m_addr;
    logic [BW-1:0] f_m_be;
    logic          f_i_val, f_d_val, f_i_wait, f_d_wait, f_m_read, f_m_write, f_err;

    cache_mem_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_i_addr(i_addr), .i_i_byte_en(i_be), .i_i_writedata(i_wd),
        .i_i_read(i_rd), .i_i_write(i_wr),
        .o_i_readdata(i_rdata), .o_i_readdata_valid(i_val), .o_i_waitrequest(i_wait),
        .i_d_addr(d_addr), .i_d_byte_en(d_be), .i_d_writedata(d_wd),
        .i_d_read(d_rd), .i_d_write(d_wr),
        .o_d_readdata(d_rdata), .o_d_readdata_valid(d_val), .o_d_waitrequest(d_wait),
        .o_m_addr(m_addr), .o_m_byte_en(m_be), .o_m_writedata(m_wd),
        .o_m_read(m_read), .o_m_write(m_write),
        .i_m_readdata(m_rd), .i_m_readdata_valid(m_val), .i_m_waitrequest(m_wait),
        .o_err(err)
    );

    cache_mem_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .i_i_addr(i_addr), .i_i_byte_en(i_be), .i_i_writedata(i_wd),
        .i_i_read(i_rd), .i_i_write(i_wr),
        .o_i_readdata(f_i_rdata), .o_i_readdata_valid(f_i_val), .o_i_waitrequest(f_i_wait),
        .i_d_addr(d_addr), .i_d_byte_en(d_be), .i_d_writedata(d_wd),
        .i_d_read(d_rd), .i_d_write(d_wr),
        .o_d_readdata(f_d_rdata), .o_d_readdata_valid(f_d_val), .o_d_waitrequest(f_d_wait),
        .o_m_addr(f_m_addr), .o_m_byte_en(f_m_be), .o_m_writedata(f_m_wd),
        .o_m_read(f_m_read), .o_m_write(f_m_write),
        .i_m_readdata(m_rd), .i_m_readdata_valid(m_val), .i_m_waitrequest(m_wait),
        .o_err(f_err)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // {m_read, m_write, i_wait, d_wait, i_valid, d_valid, err}
    function automatic logic [6:0] obs();
        return {m_read, m_write, i_wait, d_wait, i_val, d_val, err};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_rd = 0; i_wr = 0; d_rd = 0; d_wr = 0; m_wait = 0; m_val = 0;
    endtask

    typedef struct packed {
        logic       ir, iw, dr, dw, mw, mv;
        logic [6:0] exp;
    } vec_t;
    vec_t tbl [0:8];

    // reference model state
    int   mdl_gnt, mdl_last, mdl_own;
    logic mdl_wait, mdl_err;

    initial begin
        logic [3:0] rr_seq, fp_seq;
        int         rr_n, fp_n;

        tbl = '{
            {6'b100000, 7'b0011000},  // I read seen in IDLE
            {6'b100100, 7'b1001000},  // I read issued and accepted; D waits
            {6'b000100, 7'b0011000},  // read outstanding
            {6'b000100, 7'b0011000},
            {6'b000101, 7'b0011100},  // data returns to I only
            {6'b000100, 7'b0011000},  // IDLE bubble before D
            {6'b000110, 7'b0111000},  // D write stalled by memory
            {6'b000100, 7'b0110000},  // D write accepted
            {6'b000000, 7'b0011000}
        };

        i_addr = 32'h40; d_addr = 32'h80; i_be = 4'hF; d_be = 4'hF;
        i_wd = 32'h1111_1111; d_wd = 32'h2222_2222; m_rd = 32'hDEAD_BEEF;
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", obs(), 7'b0011000);
        chk("reset_ctl_fp", {f_m_read, f_m_write, f_i_wait, f_d_wait, f_i_val, f_d_val, f_err}, 7'b0011000);
        rst_n = 1;
        next_cycle();

        for (int k = 0; k < 9; k++) begin
            {i_rd, i_wr, d_rd, d_wr, m_wait, m_val} = {tbl[k].ir, tbl[k].iw, tbl[k].dr, tbl[k].dw, tbl[k].mw, tbl[k].mv};
            #4;
            chk($sformatf("vec%0d", k), obs(), tbl[k].exp);
            if (tbl[k].exp[6] | tbl[k].exp[5])
                chk($sformatf("vec%0d_addr", k), m_addr, tbl[k].exp[6] ? 32'h40 : 32'h80);
            if (tbl[k].exp[2])
                chk("vec_rdata", {i_rdata, d_rdata}, {32'hDEAD_BEEF, 32'h0});
            next_cycle();
        end

        // Simultaneous requests right after reset
        idle_inputs();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        i_wr = 1; d_wr = 1;
        rr_seq = 0; fp_seq = 0; rr_n = 0; fp_n = 0;
        for (int k = 0; k < 8; k++) begin
            #4;
            if (m_write) begin rr_seq = {rr_seq[2:0], m_addr == d_addr}; rr_n++; end
            if (f_m_write) begin fp_seq = {fp_seq[2:0], f_m_addr == d_addr}; fp_n++; end
            next_cycle();
        end
        chk("rr_order", {rr_n[3:0], rr_seq}, {4'd4, 4'b0101});
        chk("fp_order", {fp_n[3:0], fp_seq}, {4'd4, 4'b1111});
        idle_inputs();
        next_cycle();

        // Dcache write stalled 4 cycles by memory
        d_wr = 1; d_be = 4'h0F; m_wait = 1;
        #4; chk("stall_idle", {m_write, d_wait}, 2'b01);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            #4; chk($sformatf("stall%0d", k), {m_write, d_wait, m_be, m_wd}, {2'b11, 4'h0F, 32'h2222_2222});
            next_cycle();
        end
        m_wait = 0; i_wr = 1;
        #4; chk("stall_accept", {m_write, d_wait, i_wait}, 3'b101);
        next_cycle();
        d_wr = 0;
        #4; chk("post_write_idle", {m_write, i_wait}, 2'b01);
        next_cycle();
        #4; chk("next_grant", {m_write, i_wait, m_addr}, {2'b10, 32'h40});
        next_cycle();

        // Zero-latency read, then a spurious valid in IDLE
        i_wr = 0; i_rd = 1;
        #4; chk("zl_idle", i_wait, 1'b1);
        next_cycle();
        m_val = 1; m_rd = 32'h1234_5678;
        #4; chk("zl_issue", {m_read, i_wait, i_val, d_val, i_rdata}, {4'b1010, 32'h1234_5678});
        next_cycle();
        i_rd = 0;
        #4; chk("spurious", {i_val, d_val, err}, 3'b000);
        next_cycle();
        m_val = 0;
        #4; chk("spurious_err", err, 1'b1);
        next_cycle();

        // Reset while a read is outstanding
        i_rd = 1;
        next_cycle();
        #4; chk("rd_issue", m_read, 1'b1);
        next_cycle();
        i_rd = 0;
        #4; chk("rdwait", obs(), 7'b0011001);
        rst_n = 0;
        #1; chk("async_reset", obs(), 7'b0011000);
        next_cycle();
        rst_n = 1;
        m_val = 1;
        #4; chk("late_valid", {i_val, d_val}, 2'b00);
        next_cycle();
        m_val = 0;
        #4; chk("late_valid_err", err, 1'b1);
        next_cycle();

        // Random traffic against the transaction-level model
        idle_inputs();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        mdl_gnt = -1; mdl_last = 1; mdl_own = 0; mdl_wait = 0; mdl_err = 0;
        for (int k = 0; k < 400; k++) begin
            logic rdv [2];
            logic wrv [2];
            logic act, acc_rd, e_mr, e_mw;
            int   r;
            r = $urandom % 8; i_rd = (r < 3); i_wr = (r == 3 || r == 4);
            r = $urandom % 8; d_rd = (r < 3); d_wr = (r == 3 || r == 4);
            rdv[0] = i_rd; rdv[1] = d_rd; wrv[0] = i_wr; wrv[1] = d_wr;
            m_wait = ($urandom % 3 == 0);
            if (mdl_wait) m_val = ($urandom % 3 == 0);
            else if (mdl_gnt >= 0 && rdv[mdl_gnt] && !m_wait) m_val = ($urandom % 2 == 0);
            else m_val = ($urandom % 40 == 0);
            i_addr = $urandom; d_addr = $urandom; i_be = 4'($urandom); d_be = 4'($urandom);
            m_rd = $urandom;
            #4;
            e_mr = (mdl_gnt >= 0) && rdv[mdl_gnt];
            e_mw = (mdl_gnt >= 0) && wrv[mdl_gnt];
            act  = (mdl_gnt >= 0) || mdl_wait;
            chk("rand_ctl", obs(), {e_mr, e_mw, !(mdl_gnt == 0) || m_wait, !(mdl_gnt == 1) || m_wait,
                                    m_val && act && mdl_own == 0, m_val && act && mdl_own == 1, mdl_err});
            if (e_mr || e_mw)
                chk("rand_addr", {m_addr, m_be}, mdl_gnt == 0 ? {i_addr, i_be} : {d_addr, d_be});
            if (act)
                chk("rand_rdata", {i_rdata, d_rdata}, mdl_own == 0 ? {m_rd, 32'h0} : {32'h0, m_rd});
            acc_rd = e_mr && !m_wait;
            if (m_val && !mdl_wait && !acc_rd) mdl_err = 1;
            if (mdl_wait) begin
                if (m_val) mdl_wait = 0;
            end else if (mdl_gnt >= 0) begin
                if (!(e_mr || e_mw)) mdl_gnt = -1;
                else if (!m_wait) begin
                    mdl_wait = e_mr && !m_val;
                    mdl_gnt  = -1;
                end
            end else if (i_rd || i_wr || d_rd || d_wr) begin
                if ((i_rd || i_wr) && (d_rd || d_wr)) mdl_gnt = 1 - mdl_last;
                else mdl_gnt = (d_rd || d_wr) ? 1 : 0;
                mdl_last = mdl_gnt;
                mdl_own  = mdl_gnt;
            end
            next_cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
